// File: rtl/var_bw_mul_pipe.sv
// Variable-bit-width multiplier, two-stage pipeline.
// Operands are split into four quarters. Stage 1 forms all sixteen quarter
// partial products, sign-extending a quarter only when it is the most
// significant quarter of its lane and the lanes are signed. Stage 2 weights
// and sums the partial products that belong to each lane and registers the
// packed result. A single enable stalls both stages together when the
// consumer holds off.

module var_bw_mul_pipe #(
    parameter int W = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [1:0]     mode,
    input  logic           sgn,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] p,
    output logic           out_err
);

    // Quarter-lane width; derived from W and not meant to be overridden.
    localparam int LW  = W / 4;
    // Partial product width: two (LW+1)-bit signed quarters multiplied.
    localparam int PPW = 2 * LW + 2;
    // Padding needed to sign-extend a partial product to the full product width.
    localparam int PADW = 2 * W - PPW;

    localparam logic [1:0] MODE_ONE  = 2'd0;
    localparam logic [1:0] MODE_TWO  = 2'd1;
    localparam logic [1:0] MODE_FOUR = 2'd2;
    localparam logic [1:0] MODE_RSVD = 2'd3;

    // Pipeline enable shared by both stages.
    logic en;

    // Stage 1 state.
    logic           s1_valid;
    logic [1:0]     s1_mode;
    logic           s1_sgn;
    logic [PPW-1:0] s1_pp [4][4];

    // Stage 1 combinational inputs.
    logic [3:0]     top_q;
    logic [PPW-1:0] a_ext [4];
    logic [PPW-1:0] b_ext [4];
    logic [PPW-1:0] pp_next [4][4];

    // Stage 2 combinational lane combine.
    logic [2*W-1:0] term;
    logic [2*W-1:0] sum_full;
    logic [W-1:0]   sum_lo;
    logic [W-1:0]   sum_hi;
    logic [2*W-1:0] comb_p;

    // The pipeline moves whenever the output register is empty or being drained.
    always_comb begin
        en       = !out_valid || out_ready;
        in_ready = en;
    end

    // Mark which quarters carry the sign bit of their lane for the current mode.
    always_comb begin
        top_q = 4'b0000;
        case (mode)
            MODE_ONE:  top_q = 4'b1000;
            MODE_TWO:  top_q = 4'b1010;
            default:   top_q = 4'b1111;
        endcase
    end

    // Extend each quarter to PPW bits: sign-extend only lane-top quarters of signed lanes.
    always_comb begin
        for (int q = 0; q < 4; q++) begin
            a_ext[q] = {{(LW + 2){sgn & top_q[q] & a[q*LW + LW - 1]}}, a[q*LW +: LW]};
            b_ext[q] = {{(LW + 2){sgn & top_q[q] & b[q*LW + LW - 1]}}, b[q*LW +: LW]};
        end
    end

    // Form all sixteen quarter-by-quarter partial products (two's complement, PPW bits).
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pp_next[i][j] = a_ext[i] * b_ext[j];
            end
        end
    end

    // Stage 1 register: capture partial products and the controls that decide how to combine them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= MODE_ONE;
            s1_sgn   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    s1_pp[i][j] <= '0;
                end
            end
        end else if (en) begin
            s1_valid <= in_valid;
            s1_mode  <= mode;
            s1_sgn   <= sgn;
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    s1_pp[i][j] <= pp_next[i][j];
                end
            end
        end
    end

    // Weight and sum the partial products of each lane, then pack lanes by mode.
    always_comb begin
        term     = '0;
        sum_full = '0;
        sum_lo   = '0;
        sum_hi   = '0;
        comb_p   = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                term     = {{PADW{s1_sgn & s1_pp[i][j][PPW-1]}}, s1_pp[i][j]};
                sum_full = sum_full + (term << ((i + j) * LW));
                if (i < 2 && j < 2) begin
                    sum_lo = sum_lo + (term[W-1:0] << ((i + j) * LW));
                end
                if (i >= 2 && j >= 2) begin
                    sum_hi = sum_hi + (term[W-1:0] << ((i + j - 4) * LW));
                end
            end
        end
        case (s1_mode)
            MODE_ONE: comb_p = sum_full;
            MODE_TWO: comb_p = {sum_hi, sum_lo};
            MODE_FOUR: begin
                for (int k = 0; k < 4; k++) begin
                    comb_p[k*2*LW +: 2*LW] = s1_pp[k][k][2*LW-1:0];
                end
            end
            default:  comb_p = '0;
        endcase
    end

    // Stage 2 register: present the packed product, flagging reserved-mode results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            p         <= '0;
        end else if (en) begin
            out_valid <= s1_valid;
            out_err   <= s1_valid && (s1_mode == MODE_RSVD);
            p         <= s1_valid ? comb_p : '0;
        end
    end

endmodule

// File: tb/tb_var_bw_mul_pipe.sv
// Scoreboard bench for var_bw_mul_pipe at W=16: expected products are
// queued on acceptance and a monitor pops and compares on each output transfer.

module tb_var_bw_mul_pipe;

    localparam int W = 16;

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     mode;
    logic           sgn;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] p;
    logic           out_err;

    typedef struct {
        logic [31:0] p;
        logic        err;
    } exp_t;

    exp_t sb[$];

    int check_count = 0;
    int pass_count  = 0;

    // Hand-computed vector table.
    logic [1:0]  v_mode [14] = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd0,
                                 2'd0, 2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd0};
    logic        v_sgn  [14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] v_a    [14] = '{16'hFFFF, 16'h0302, 16'hFF02, 16'h000F, 16'h000F, 16'h1234, 16'h1234,
                                 16'hFFFF, 16'h8000, 16'h8080, 16'hFFFF, 16'hFFFF, 16'h8765, 16'hFFFE};
    logic [15:0] v_b    [14] = '{16'hFFFF, 16'h0504, 16'h0504, 16'h0002, 16'h0002, 16'h5678, 16'h0010,
                                 16'hFFFF, 16'h8000, 16'h7F80, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h0003};
    logic [31:0] v_p    [14] = '{32'hFFFE0001, 32'h000F0008, 32'hFFFB0008, 32'h000000FE, 32'h0000001E,
                                 32'h00000000, 32'h00012340, 32'h00000001, 32'h40000000, 32'hC0804000,
                                 32'hE1E1E1E1, 32'h01010101, 32'hF80E1214, 32'hFFFFFFFA};
    logic        v_err  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    var_bw_mul_pipe #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .sgn       (sgn),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .p         (p),
        .out_err   (out_err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point used by every check in the bench.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        check_count++;
        if (act === req) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one vector starting at a falling edge; queue its expectation when it is accepted.
    task automatic applyStimulus(input int idx);
        int   tries;
        exp_t e;
        tries    = 0;
        mode     = v_mode[idx];
        sgn      = v_sgn[idx];
        a        = v_a[idx];
        b        = v_b[idx];
        in_valid = 1'b1;
        #1;
        while (!in_ready && tries < 50) begin
            @(negedge clk);
            #1;
            tries++;
        end
        if (!in_ready) begin
            checkOutput("accept_timeout", 32'(0), 32'(1));
        end else begin
            e.p   = v_p[idx];
            e.err = v_err[idx];
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    // Wait, bounded, until every queued expectation has been consumed.
    task automatic waitDrain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        checkOutput("drain_empty", 32'(sb.size()), 32'(0));
    endtask

    // Monitor: on every output transfer pop the oldest expectation and compare.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_output", 32'(1), 32'(0));
                end else begin
                    e = sb.pop_front();
                    checkOutput("product", p, e.p);
                    checkOutput("out_err", 32'(out_err), 32'(e.err));
                end
            end
        end
    end

    // Main directed sequence.
    initial begin
        logic [31:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        mode      = 2'd0;
        sgn       = 1'b0;
        a         = '0;
        b         = '0;

        #2;
        checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
        checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
        checkOutput("rst_p", p, 32'(0));
        checkOutput("rst_out_err", 32'(out_err), 32'(0));

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Latency: accepted in cycle t, visible in cycle t+2.
        applyStimulus(0);
        in_valid = 1'b0;
        checkOutput("lat_t1_valid", 32'(out_valid), 32'(0));
        @(negedge clk);
        #2;
        checkOutput("lat_t2_valid", 32'(out_valid), 32'(1));
        waitDrain();
        @(negedge clk);

        // Mixed modes back to back, including reserved mode followed by mode 0.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(i);
        end
        in_valid = 1'b0;
        waitDrain();
        @(negedge clk);

        // Six back-to-back vectors with a three-cycle consumer stall mid-stream.
        fork
            begin
                for (int i = 7; i <= 12; i++) begin
                    applyStimulus(i);
                end
                in_valid = 1'b0;
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                #2;
                checkOutput("stall_valid", 32'(out_valid), 32'(1));
                checkOutput("stall_in_ready", 32'(in_ready), 32'(0));
                held = p;
                repeat (2) begin
                    @(negedge clk);
                    #2;
                    checkOutput("stall_p_hold", p, held);
                    checkOutput("stall_in_ready_hold", 32'(in_ready), 32'(0));
                end
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        waitDrain();
        @(negedge clk);

        // Asynchronous reset with two transactions in flight and the consumer stalled.
        out_ready = 1'b0;
        applyStimulus(13);
        applyStimulus(1);
        in_valid = 1'b0;
        checkOutput("pre_rst_valid", 32'(out_valid), 32'(1));
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", 32'(out_valid), 32'(0));
        checkOutput("async_rst_in_ready", 32'(in_ready), 32'(1));
        checkOutput("async_rst_p", p, 32'(0));
        checkOutput("async_rst_err", 32'(out_err), 32'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #2;
            checkOutput("no_stale_output", 32'(out_valid), 32'(0));
        end

        // Pipeline is usable again after reset.
        @(negedge clk);
        applyStimulus(13);
        in_valid = 1'b0;
        waitDrain();

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
